lzrw_decompressor_stream: RTL and testbench
===========================================

# lzrw_decompressor_stream

Parametrised second-generation LZRW1 decompressor for the decompression path: consumes literal/copy tokens on a valid/ready input and emits one decoded byte per cycle on a valid/ready output with full backpressure. Generalises history depth and token field widths, handles overlapping copies including offset 1, and optionally flags copies that reference bytes never written. Sits between the token unpacker and the byte sink.

## Interface
- HISTORY_SIZE, 4096: history depth in bytes; power of two, 16..65536.
- LENGTH_WIDTH, 4: width of the copy-length field.
- MIN_MATCH, 1: copy length = length field + MIN_MATCH; range 1..3.
- OFFSET_WIDTH (localparam): $clog2(HISTORY_SIZE).
- TOKEN_WIDTH (localparam): LENGTH_WIDTH+OFFSET_WIDTH; must be ≥ 8.
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_token  in  TOKEN_WIDTH  literal: byte in [7:0], upper bits ignored; copy: {length, offset}, offset in LSBs.
- in_ctrl  in  1  0 = literal, 1 = copy.
- in_valid  in  1  token present.
- in_ready  out  1  token accepted when in_valid && in_ready.
- out_byte  out  8  decoded byte.
- out_valid  out  1  out_byte valid; held stable until accepted.
- out_ready  in  1  sink accepts when out_valid && out_ready.
- busy  out  1  high in any state except IDLE.
- history_full  out  1  sticky: HISTORY_SIZE bytes written since reset.
- out_count  out  32  bytes emitted since reset; wraps.
- error  out  1  sticky range error (present only with macro; else tied 0).

## Operation
- History: internal HISTORY_SIZE×8 RAM, synchronous write, 1-cycle registered read. wr_ptr and fill_count (saturates at HISTORY_SIZE) track written bytes. All pointer arithmetic is modulo HISTORY_SIZE.
- States: IDLE, LIT, FETCH, COPY.
- IDLE: in_ready=1. Literal accepted → write byte at wr_ptr, wr_ptr++, capture byte, → LIT. Copy accepted → rd_ptr = wr_ptr − offset, remaining = length+MIN_MATCH, → FETCH.
- LIT: out_valid=1 with captured byte; on out_ready → IDLE.
- FETCH: RAM read of rd_ptr issued; one cycle → COPY.
- COPY: out_valid=1, out_byte = RAM data (or forwarded byte). On handshake: write out_byte at wr_ptr, wr_ptr++, rd_ptr++, remaining−−, read of next rd_ptr issued same cycle; remaining reaching 0 → IDLE. Without handshake, all state held and out_byte stable.
- Overlap: offset 1 makes next rd_ptr equal the address written this cycle; the written byte is forwarded into out_byte in place of the RAM read. Offset ≥ 2 reads from the RAM normally.
- Offset 0: treated as offset HISTORY_SIZE (the oldest byte).
- out_count increments on every output handshake.

## Timing
- Reset: state IDLE, in_ready 1, out_valid 0, out_byte 0, busy 0, history_full 0, out_count 0, error 0, wr_ptr 0, fill_count 0. RAM contents are not cleared.
- Reset asserted mid-copy: the copy is aborted immediately and no further out_valid is issued. The output sequence restarts from empty history.
- Literal latency: accepted at edge t; out_valid from t+1.
- Copy latency: accepted at edge t; FETCH during t+1; first byte valid from t+2. Thereafter 1 byte/cycle with out_ready held high.
- Token throughput: in_ready is low outside IDLE, so there is one idle-to-accept cycle between tokens.
- Wrap: wr_ptr and rd_ptr wrap from HISTORY_SIZE−1 to 0 with no bubble.
- history_full rises in the cycle after the write that makes fill_count reach HISTORY_SIZE.

## Configuration
- LZRW_DECOMP_RANGE_CHECK_EN defined:
  - A copy token is rejected if, at acceptance, the effective offset exceeds fill_count, or length+MIN_MATCH exceeds HISTORY_SIZE.
  - A rejected token produces no output and the block returns to IDLE on the next cycle.
  - error sets and stays high until reset.
- LZRW_DECOMP_RANGE_CHECK_EN undefined: no check is made; error is constant 0; out-of-range copies emit whatever the RAM holds.

## Test plan
- Reset; literals 0x41, 0x42, 0x43 with out_ready=1 → out_byte A,B,C; out_count=3; each byte appears 1 cycle after its acceptance.
- After "ABC", copy offset=3, length field=5 (MIN_MATCH=1) → "ABCABC"; first byte 2 cycles after acceptance; out_count=9.
- Literal 0x5A, then copy offset=1, length field=7 → eight 0x5A bytes on consecutive cycles. This exercises the forwarding path.
- During a copy, toggle out_ready as 1,0,0,1,… → no byte is lost or duplicated, and out_byte is stable while stalled.
- HISTORY_SIZE=16: write 20 literals, then copy offset=16 → returns literal #5; history_full=1; pointers wrapped correctly.
- Macro on: after 2 literals, copy offset=5 → no out_valid, error=1 and sticky, block back in IDLE. Macro off: same stimulus emits 1+MIN_MATCH-adjusted bytes and error stays 0.

Source files
------------

// File: rtl/lzrw_decompressor_stream.sv
// LZRW1 token decompressor: literal/copy tokens in, one decoded byte per cycle out.
// Optional copy range checking is enabled by defining LZRW_DECOMP_RANGE_CHECK_EN.
module lzrw_decompressor_stream #(
  parameter  int unsigned HISTORY_SIZE = 4096,
  parameter  int unsigned LENGTH_WIDTH = 4,
  parameter  int unsigned MIN_MATCH    = 1,
  localparam int unsigned OFFSET_WIDTH = $clog2(HISTORY_SIZE),
  localparam int unsigned TOKEN_WIDTH  = LENGTH_WIDTH + OFFSET_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [TOKEN_WIDTH-1:0] in_token,
  input  logic                   in_ctrl,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   history_full,
  output logic [31:0]            out_count,
  output logic                   error
);

  localparam int unsigned REM_W  = LENGTH_WIDTH + 2;
  localparam int unsigned FILL_W = OFFSET_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, LIT, FETCH, COPY} state_t;

  state_t                  state;
  logic [7:0]              mem [HISTORY_SIZE];
  logic [OFFSET_WIDTH-1:0] wr_ptr, rd_ptr, rd_addr, tok_offset;
  logic [LENGTH_WIDTH-1:0] tok_length;
  logic [REM_W-1:0]        remaining, copy_total;
  logic [FILL_W-1:0]       fill_count;
  logic [7:0]              lit_byte, rd_data, fwd_byte, wr_data;
  logic                    fwd_sel, rd_en, wr_en;
  logic                    lit_acc, copy_req, copy_acc, copy_ok, out_hs;

  assign tok_offset = in_token[OFFSET_WIDTH-1:0];
  assign tok_length = in_token[TOKEN_WIDTH-1:OFFSET_WIDTH];
  assign copy_total = REM_W'(tok_length) + REM_W'(MIN_MATCH);

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == LIT) || (state == COPY);
  assign out_byte  = (state == COPY) ? (fwd_sel ? fwd_byte : rd_data) : lit_byte;

  assign lit_acc  = in_valid && in_ready && !in_ctrl;
  assign copy_req = in_valid && in_ready && in_ctrl;
  assign copy_acc = copy_req && copy_ok;
  assign out_hs   = out_valid && out_ready;

`ifdef LZRW_DECOMP_RANGE_CHECK_EN
  logic [FILL_W-1:0] eff_offset;

  // Offset 0 addresses the oldest byte, i.e. a full history back.
  assign eff_offset = (tok_offset == '0) ? FILL_W'(HISTORY_SIZE) : FILL_W'(tok_offset);
  assign copy_ok    = !(eff_offset > fill_count) && !(32'(copy_total) > HISTORY_SIZE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                    error <= 1'b0;
    else if (copy_req && !copy_ok) error <= 1'b1;
  end
`else
  assign copy_ok = 1'b1;
  assign error   = 1'b0;
`endif

  assign wr_en   = lit_acc || ((state == COPY) && out_hs);
  assign wr_data = lit_acc ? in_token[7:0] : out_byte;
  assign rd_en   = (state == FETCH) || ((state == COPY) && out_hs);
  assign rd_addr = (state == FETCH) ? rd_ptr : rd_ptr + OFFSET_WIDTH'(1);

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      remaining    <= '0;
      fill_count   <= '0;
      lit_byte     <= '0;
      fwd_byte     <= '0;
      fwd_sel      <= 1'b0;
      history_full <= 1'b0;
      out_count    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + OFFSET_WIDTH'(1);
        if (fill_count != FILL_W'(HISTORY_SIZE)) fill_count <= fill_count + FILL_W'(1);
        if (fill_count == FILL_W'(HISTORY_SIZE - 1)) history_full <= 1'b1;
      end
      if (out_hs) out_count <= out_count + 32'd1;
      case (state)
        IDLE: begin
          if (lit_acc) begin
            lit_byte <= in_token[7:0];
            state    <= LIT;
          end else if (copy_acc) begin
            rd_ptr    <= wr_ptr - tok_offset;
            remaining <= copy_total;
            fwd_sel   <= 1'b0;
            state     <= FETCH;
          end
        end
        LIT:   if (out_ready) state <= IDLE;
        FETCH: state <= COPY;
        COPY: begin
          if (out_hs) begin
            rd_ptr    <= rd_addr;
            remaining <= remaining - REM_W'(1);
            // Next read hits the address being written now (offset 1): the
            // RAM would return stale data, so take the byte being written.
            fwd_sel   <= (rd_addr == wr_ptr);
            fwd_byte  <= out_byte;
            if (remaining == REM_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lzrw_decompressor_stream.sv
// Directed bench for lzrw_decompressor_stream (16-byte history) with a byte scoreboard.
module tb_lzrw_decompressor_stream;

  localparam int unsigned HS = 16;
  localparam int unsigned LW = 4;
  localparam int unsigned OW = 4;
  localparam int unsigned TW = LW + OW;
  localparam int unsigned MM = 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [TW-1:0] in_token;
  logic          in_ctrl, in_valid, in_ready;
  logic [7:0]    out_byte;
  logic          out_valid, out_ready, busy, history_full, error;
  logic [31:0]   out_count;

  always #5 clock = ~clock;

  lzrw_decompressor_stream #(
    .HISTORY_SIZE(HS),
    .LENGTH_WIDTH(LW),
    .MIN_MATCH   (MM)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_token    (in_token),
    .in_ctrl     (in_ctrl),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .history_full(history_full),
    .out_count   (out_count),
    .error       (error)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [7:0]  sb [$];
  logic [7:0]  hist [HS];
  int unsigned m_wp, m_fill, m_count;
  logic        stalled = 1'b0;
  logic [7:0]  held, exp_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: compare each byte as it is about to be accepted by the sink.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (stalled) begin
        chk("stall_valid_held", 32'(out_valid), 32'd1);
        chk("stall_byte_stable", 32'(out_byte), 32'(held));
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        stalled = 1'b0;
        n_cmp++;
        assert (sb.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_byte: observed %0h expected none", out_byte);
        end
        if (sb.size() > 0) begin
          exp_b = sb.pop_front();
          chk("out_byte", 32'(out_byte), 32'(exp_b));
        end
      end else if (out_valid === 1'b1) begin
        stalled = 1'b1;
        held    = out_byte;
      end else begin
        stalled = 1'b0;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    m_wp    = 0;
    m_fill  = 0;
    m_count = 0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  task automatic m_write(input logic [7:0] b);
    hist[m_wp] = b;
    m_wp = (m_wp + 1) % HS;
    if (m_fill < HS) m_fill++;
    sb.push_back(b);
    m_count++;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (in_ready === 1'b1) return;
      step();
    end
    n_cmp++;
    n_fail++;
    $error("FAIL ready_timeout: observed in_ready %0b expected 1", in_ready);
  endtask

  task automatic drain(input bit toggle);
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0 && in_ready === 1'b1) begin
        out_ready = 1'b1;
        return;
      end
      if (toggle) out_ready = pat[i % 4];
      step();
    end
    out_ready = 1'b1;
    n_cmp++;
    n_fail++;
    $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
  endtask

  task automatic send_lit(input logic [7:0] b, input bit lat);
    wait_idle();
    in_valid = 1'b1;
    in_ctrl  = 1'b0;
    in_token = TW'(b);
    m_write(b);
    step();
    in_valid = 1'b0;
    if (lat) begin
      @(negedge clock);
      chk("lit_latency", 32'(out_valid), 32'd1);
      step();
    end
  endtask

  task automatic send_copy(input int unsigned len, input int unsigned off, input bit lat);
    logic [LW-1:0] l;
    logic [OW-1:0] o;
    int unsigned   eff, total;
    bit            reject;
    l      = len[LW-1:0];
    o      = off[OW-1:0];
    eff    = (off == 0) ? HS : off;
    total  = len + MM;
    reject = 1'b0;
`ifdef LZRW_DECOMP_RANGE_CHECK_EN
    reject = (eff > m_fill) || (total > HS);
`endif
    wait_idle();
    in_valid = 1'b1;
    in_ctrl  = 1'b1;
    in_token = {l, o};
    if (!reject)
      for (int i = 0; i < int'(total); i++) m_write(hist[(m_wp + HS - eff) % HS]);
    step();
    in_valid = 1'b0;
    if (lat && !reject) begin
      @(negedge clock);
      chk("copy_fetch_bubble", 32'(out_valid), 32'd0);
      chk("copy_busy", 32'(busy), 32'd1);
      @(negedge clock);
      chk("copy_first_valid", 32'(out_valid), 32'd1);
      for (int i = 1; i < int'(total); i++) begin
        @(negedge clock);
        chk("copy_stream", 32'(out_valid), 32'd1);
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = 1'b0;
    in_token  = '0;
    out_ready = 1'b1;
    m_wp = 0; m_fill = 0; m_count = 0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_byte", 32'(out_byte), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_history_full", 32'(history_full), 32'd0);
    chk("rst_out_count", out_count, 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    repeat (2) step();
    reset = 1'b1;
    step();

    // "ABC" then "ABCABC"
    send_lit(8'h41, 1'b1);
    send_lit(8'h42, 1'b1);
    send_lit(8'h43, 1'b1);
    drain(1'b0);
    chk("count_abc", out_count, 32'd3);
    send_copy(5, 3, 1'b1);
    drain(1'b0);
    chk("count_abcabc", out_count, 32'd9);

    // offset 1 run-length expansion
    send_lit(8'h5A, 1'b1);
    send_copy(7, 1, 1'b1);
    drain(1'b0);
    chk("count_rle", out_count, 32'd18);

    // backpressure during an overlapping copy
    send_copy(10, 2, 1'b0);
    drain(1'b1);
    chk("count_stall", out_count, m_count);

    // wrap and history_full with a fresh history
    do_reset();
    chk("hf_after_reset", 32'(history_full), 32'd0);
    for (int k = 0; k < 20; k++) begin
      send_lit(8'h60 + 8'(k), 1'b0);
      if (k == 14) chk("hf_at_15", 32'(history_full), 32'd0);
      if (k == 15) chk("hf_at_16", 32'(history_full), 32'd1);
    end
    drain(1'b0);
    send_copy(3, 0, 1'b1);
    drain(1'b0);
    chk("count_wrap", out_count, 32'd24);
    chk("hf_sticky", 32'(history_full), 32'd1);

    // copy reaching beyond the bytes written since reset
    do_reset();
    send_lit(8'h11, 1'b1);
    send_lit(8'h22, 1'b1);
    drain(1'b0);
    send_copy(1, 5, 1'b1);
`ifdef LZRW_DECOMP_RANGE_CHECK_EN
    chk("range_error", 32'(error), 32'd1);
    chk("range_idle", 32'(in_ready), 32'd1);
    chk("range_no_valid", 32'(out_valid), 32'd0);
    repeat (2) step();
    chk("range_error_sticky", 32'(error), 32'd1);
    send_lit(8'h33, 1'b1);
    drain(1'b0);
    chk("range_error_kept", 32'(error), 32'd1);
    chk("range_count", out_count, 32'd3);
`else
    drain(1'b0);
    chk("range_no_error", 32'(error), 32'd0);
    chk("range_count", out_count, 32'd4);
`endif

    // reset in the middle of a copy
    send_lit(8'h77, 1'b1);
    drain(1'b0);
    send_copy(7, 1, 1'b0);
    repeat (3) step();
    do_reset();
    chk("midrst_count", out_count, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    step();
    send_lit(8'h99, 1'b1);
    drain(1'b0);
    chk("midrst_restart_count", out_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
